// File: rtl/posit_encoder.sv
// Final posit packing stage: regime/exponent/fraction packing, RNE rounding,
// saturation and sign negation, with a valid/ack handshake on both sides.
module posit_encoder #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         sign_in,
  input  logic         zero_in,
  input  logic         nar_in,
  input  logic [5:0]   adj_k,
  input  logic [2:0]   adj_exp,
  input  logic [63:0]  mant_adj,
  input  logic         out_ack,
  output logic         recieved,
  output logic [N-1:0] posit_out,
  output logic         out_valid,
  output logic         busy
);

  localparam int ES = 3;
  localparam logic signed [7:0] SAT_HI = 8'(N-2);
  localparam logic signed [7:0] SAT_LO = -SAT_HI;

  typedef enum logic [2:0] {IDLE, LOAD, PACK, ROUND, DONE} state_t;

  state_t r_state, w_state_nxt;

  logic              r_armed, r_busy;
  logic              r_sign, r_zero, r_nar;
  logic [5:0]        r_k;
  logic [ES-1:0]     r_exp;
  logic [61:0]       r_frac;
  logic [N-2:0]      r_body;
  logic              r_guard, r_sticky;
  logic [N-1:0]      r_posit;

  logic              w_capture;
  logic signed [7:0] w_k;
  logic [7:0]        w_kneg;
  logic [6:0]        w_run, w_len;
  logic [ES+61:0]    w_tail;
  logic [127:0]      w_regime, w_f;
  logic              w_rnd_up;
  logic [N-2:0]      w_body_r;
  logic [N-1:0]      w_word, w_mag;
  logic              w_unused_msb;

  // The leading "01" of the normalised mantissa is implied by the format.
  assign w_unused_msb = &{1'b0, mant_adj[63:62]};

  assign w_capture = (r_state == IDLE) && in_valid && r_armed;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = PACK;
      PACK:    w_state_nxt = ROUND;
      ROUND:   w_state_nxt = DONE;
      DONE:    if (out_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      // Upstream done may linger after the acknowledge; re-arm only once it drops.
      if (w_capture)     r_armed <= 1'b0;
      else if (!in_valid) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_zero <= 1'b0;
      r_nar  <= 1'b0;
      r_k    <= '0;
      r_exp  <= '0;
      r_frac <= '0;
    end else if (w_capture) begin
      r_sign <= sign_in;
      r_zero <= zero_in;
      r_nar  <= nar_in;
      r_k    <= adj_k;
      r_exp  <= adj_exp;
      r_frac <= mant_adj[61:0];
    end
  end

  // Extended body in a 128-bit frame: regime run, terminator, exponent, fraction.
  assign w_k    = {{2{r_k[5]}}, r_k};
  assign w_kneg = -w_k;
  assign w_tail = {r_exp, r_frac};

  always_comb begin
    w_run    = '0;
    w_regime = '0;
    if (!r_k[5]) begin
      w_run    = {1'b0, r_k} + 7'd1;
      w_regime = ~({128{1'b1}} >> w_run);
    end else begin
      w_run    = w_kneg[6:0];
      w_regime = {1'b1, 127'b0} >> w_run;
    end
  end

  assign w_len = w_run + 7'd1;
  assign w_f   = w_regime | ({w_tail, {(128-ES-62){1'b0}}} >> w_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_body   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
    end else if (r_state == PACK) begin
      r_body   <= w_f[127 -: (N-1)];
      r_guard  <= w_f[128-N];
      r_sticky <= |(w_f & ({128{1'b1}} >> N));
    end
  end

  assign w_rnd_up = r_guard & (r_sticky | r_body[0]);

  always_comb begin
    w_body_r = r_body;
    if (w_rnd_up && !(&r_body)) w_body_r = r_body + 1'b1;
    // Saturation wins over rounding; a nonzero value never collapses to zero.
    if (w_k >= SAT_HI)      w_body_r = '1;
    else if (w_k <= SAT_LO) w_body_r = {{(N-2){1'b0}}, 1'b1};
  end

  assign w_mag = {1'b0, w_body_r};

  always_comb begin
    w_word = r_sign ? (~w_mag + 1'b1) : w_mag;
    if (r_nar)       w_word = {1'b1, {(N-1){1'b0}}};
    else if (r_zero) w_word = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_posit <= '0;
    else if (r_state == ROUND) r_posit <= w_word;
  end

  assign recieved  = (r_state == LOAD);
  assign out_valid = (r_state == DONE);
  assign busy      = r_busy;
  assign posit_out = r_posit;

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (N=32): encodings, rounding, saturation,
// specials and handshake behaviour with hand-computed expected words.
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, sign_in, zero_in, nar_in, out_ack;
  logic [5:0]  adj_k;
  logic [2:0]  adj_exp;
  logic [63:0] mant_adj;
  logic        recieved, out_valid, busy;
  logic [31:0] posit_out;

  int errors = 0;
  int checks = 0;
  int recv_cnt = 0;
  int ov_cnt = 0;

  localparam logic [63:0] ONE = 64'h4000_0000_0000_0000;

  posit_encoder #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sign_in(sign_in),
    .zero_in(zero_in), .nar_in(nar_in), .adj_k(adj_k), .adj_exp(adj_exp),
    .mant_adj(mant_adj), .out_ack(out_ack), .recieved(recieved),
    .posit_out(posit_out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (recieved)  recv_cnt++;
    if (out_valid) ov_cnt++;
  end

  // Drives one transaction with out_ack held high; returns word, latency, and out_valid one edge later.
  task automatic run_op(input logic s, input logic z, input logic n, input logic [5:0] k,
                        input logic [2:0] e, input logic [63:0] m,
                        output logic [31:0] res, output int lat, output logic ov_after);
    @(negedge clk);
    sign_in = s; zero_in = z; nar_in = n; adj_k = k; adj_exp = e; mant_adj = m;
    in_valid = 1'b1; out_ack = 1'b1;
    lat = -1; res = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (recieved) in_valid = 1'b0;
      if (out_valid) begin lat = c; res = posit_out; break; end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    ov_after = out_valid;
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; sign_in = 0; zero_in = 0; nar_in = 0;
    out_ack = 0; adj_k = 0; adj_exp = 0; mant_adj = 0;
    #3;
    checks++; if (recieved !== 1'b0) begin errors++; $display("FAIL reset_recieved: got %b want 0", recieved); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (posit_out !== 32'h0) begin errors++; $display("FAIL reset_posit: got %h want 0", posit_out); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat; logic ova; int r0;
    r0 = recv_cnt;
    run_op(0, 0, 0, 6'd0, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL one: got %h want 40000000", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL latency: got %0d want 4", lat); end
    checks++; if (ova !== 1'b0) begin errors++; $display("FAIL ov_one_cycle: got %b want 0", ova); end
    checks++; if (recv_cnt - r0 !== 1) begin errors++; $display("FAIL recv_pulse: got %0d want 1", recv_cnt - r0); end
  endtask

  task automatic test_values();
    logic [31:0] r; int lat; logic ova;
    run_op(1, 0, 0, 6'd0, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'hC000_0000) begin errors++; $display("FAIL neg_one: got %h want c0000000", r); end
    run_op(0, 0, 0, 6'h3F, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'h2000_0000) begin errors++; $display("FAIL k_m1: got %h want 20000000", r); end
    run_op(0, 0, 0, 6'd1, 3'd5, ONE, r, lat, ova);
    checks++; if (r !== 32'h6A00_0000) begin errors++; $display("FAIL k1_e5: got %h want 6a000000", r); end
  endtask

  task automatic test_round();
    logic [31:0] r; int lat; logic ova;
    run_op(0, 0, 0, 6'd0, 3'd0, 64'h4000_0008_0000_0000, r, lat, ova);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL tie_even: got %h want 40000000", r); end
    run_op(0, 0, 0, 6'd0, 3'd0, 64'h4000_0018_0000_0000, r, lat, ova);
    checks++; if (r !== 32'h4000_0002) begin errors++; $display("FAIL tie_odd: got %h want 40000002", r); end
    run_op(0, 0, 0, 6'd0, 3'd0, 64'h4000_0008_0000_0001, r, lat, ova);
    checks++; if (r !== 32'h4000_0001) begin errors++; $display("FAIL sticky: got %h want 40000001", r); end
  endtask

  task automatic test_saturation();
    logic [31:0] r; int lat; logic ova;
    run_op(0, 0, 0, 6'd30, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_k30: got %h want 7fffffff", r); end
    run_op(1, 0, 0, 6'd31, 3'd7, ONE, r, lat, ova);
    checks++; if (r !== 32'h8000_0001) begin errors++; $display("FAIL sat_k31_neg: got %h want 80000001", r); end
    run_op(0, 0, 0, 6'h20, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL sat_km32: got %h want 00000001", r); end
    run_op(0, 0, 0, 6'h22, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL sat_km30: got %h want 00000001", r); end
  endtask

  task automatic test_specials();
    logic [31:0] r; int lat; logic ova;
    run_op(1, 1, 0, 6'd3, 3'd2, ONE, r, lat, ova);
    checks++; if (r !== 32'h0000_0000) begin errors++; $display("FAIL zero: got %h want 00000000", r); end
    run_op(0, 1, 1, 6'd3, 3'd2, ONE, r, lat, ova);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL nar: got %h want 80000000", r); end
  endtask

  task automatic test_hold_valid();
    int r0, o0;
    r0 = recv_cnt; o0 = ov_cnt;
    @(negedge clk);
    sign_in = 0; zero_in = 0; nar_in = 0; adj_k = 6'h3F; adj_exp = 0; mant_adj = ONE;
    in_valid = 1'b1; out_ack = 1'b1;
    repeat (8) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (recv_cnt - r0 !== 1) begin errors++; $display("FAIL hold_captures: got %0d want 1", recv_cnt - r0); end
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL hold_results: got %0d want 1", ov_cnt - o0); end
    checks++; if (posit_out !== 32'h2000_0000) begin errors++; $display("FAIL hold_value: got %h want 20000000", posit_out); end
    out_ack = 1'b0;
  endtask

  task automatic test_stall();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    sign_in = 1; zero_in = 0; nar_in = 0; adj_k = 0; adj_exp = 0; mant_adj = ONE;
    in_valid = 1'b1; out_ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (recieved) in_valid = 1'b0;
      if (out_valid) begin seen = 1'b1; break; end
    end
    in_valid = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_timeout: got %b want 1", seen); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || posit_out !== 32'hC000_0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got ov=%b busy=%b %h want ov=1 busy=1 c0000000", out_valid, busy, posit_out);
      end
    end
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || posit_out !== 32'hC000_0000) begin
      errors++; $display("FAIL stall_after: got busy=%b %h want busy=0 c0000000", busy, posit_out); end
  endtask

  task automatic test_mid_reset();
    int o0;
    logic [31:0] r; int lat; logic ova;
    @(negedge clk);
    sign_in = 0; zero_in = 0; nar_in = 0; adj_k = 6'd1; adj_exp = 3'd5; mant_adj = ONE;
    in_valid = 1'b1; out_ack = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (posit_out !== 32'h0 || out_valid !== 1'b0 || recieved !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got %h ov=%b rcv=%b busy=%b want 0 0 0 0", posit_out, out_valid, recieved, busy); end
    o0 = ov_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (ov_cnt !== o0 || posit_out !== 32'h0) begin
      errors++; $display("FAIL mid_no_output: got pulses=%0d %h want 0 00000000", ov_cnt - o0, posit_out); end
    out_ack = 1'b0;
    run_op(0, 0, 0, 6'd0, 3'd0, ONE, r, lat, ova);
    checks++; if (r !== 32'h4000_0000 || lat !== 4) begin
      errors++; $display("FAIL post_reset: got %h lat=%0d want 40000000 lat=4", r, lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_round();
    test_saturation();
    test_specials();
    test_hold_valid();
    test_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
